// File: rtl/minmax_tracker.sv
// minmax_tracker
// Tracks the running maximum and minimum of a 4-bit unsigned sample stream.
// One external magnitude comparator is time-shared: each accepted sample is
// compared first against Max, then against Min. The comparator sits outside
// this block and is wired to the Cmp* ports.
//
// Ports
//   Clk        system clock, rising edge
//   Reset      synchronous active-high reset (also clears CmpError)
//   Clear      synchronous statistics clear, aborts an in-flight sample
//   InValid    sample source has data      InReady  block accepts this cycle
//   InData     4-bit unsigned sample
//   CmpA/CmpB  comparator operands         CmpEqual/CmpBigA/CmpBigB  results
//   Max/Min    running statistics          Count    saturating sample count
//   Empty      Count == 0
//   Update     one-cycle pulse when Max/Min/Count reflect a finished sample
//   NewMax     with Update: sample strictly exceeded previous Max
//   NewMin     with Update: sample strictly below previous Min
//   CmpError   sticky: comparator result was not one-hot in a compare state
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | ready for a sample; first sample after Empty is absorbed here
// CMP_MAX | comparator driven with Sample vs Max
// CMP_MIN | comparator driven with Sample vs Min, then count the sample

module minmax_tracker #(
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Clear,
  input  logic                   InValid,
  output logic                   InReady,
  input  logic [3:0]             InData,
  output logic [3:0]             CmpA,
  output logic [3:0]             CmpB,
  input  logic                   CmpEqual,
  input  logic                   CmpBigA,
  input  logic                   CmpBigB,
  output logic [3:0]             Max,
  output logic [3:0]             Min,
  output logic [COUNT_WIDTH-1:0] Count,
  output logic                   Empty,
  output logic                   Update,
  output logic                   NewMax,
  output logic                   NewMin,
  output logic                   CmpError
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMP_MAX = 2'd1,
    CMP_MIN = 2'd2
  } state_e;

  state_e                 state_q;
  logic [3:0]             sample_q;
  logic [3:0]             max_q;
  logic [3:0]             min_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;
  logic                   in_ready_q;
  logic [3:0]             cmp_a_q;
  logic [3:0]             cmp_b_q;
  logic                   update_q;
  logic                   new_max_q;
  logic                   new_min_q;
  logic                   new_max_seen_q;
  logic                   cmp_err_q;
  logic                   empty;
  logic                   cmp_onehot;
  logic                   in_cmp_state;

  assign empty        = (count_q == '0);
  assign count_d      = (count_q == {COUNT_WIDTH{1'b1}}) ? count_q
                                                         : count_q + COUNT_WIDTH'(1);
  assign cmp_onehot   = ({CmpEqual, CmpBigA, CmpBigB} == 3'b100) ||
                        ({CmpEqual, CmpBigA, CmpBigB} == 3'b010) ||
                        ({CmpEqual, CmpBigA, CmpBigB} == 3'b001);
  assign in_cmp_state = (state_q == CMP_MAX) || (state_q == CMP_MIN);

  // Operands and ready are registered alongside the state so they are valid
  // in the very cycle the state they belong to is entered.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= IDLE;
      sample_q       <= '0;
      max_q          <= '0;
      min_q          <= '0;
      count_q        <= '0;
      in_ready_q     <= 1'b1;
      cmp_a_q        <= '0;
      cmp_b_q        <= '0;
      update_q       <= 1'b0;
      new_max_q      <= 1'b0;
      new_min_q      <= 1'b0;
      new_max_seen_q <= 1'b0;
      cmp_err_q      <= 1'b0;
    end else begin
      // The comparator was really driven this cycle, so a bad result is
      // recorded even if Clear aborts the sequence at the same time.
      if (in_cmp_state && !cmp_onehot) begin
        cmp_err_q <= 1'b1;
      end
      update_q  <= 1'b0;
      new_max_q <= 1'b0;
      new_min_q <= 1'b0;

      if (Clear) begin
        state_q        <= IDLE;
        max_q          <= '0;
        min_q          <= '0;
        count_q        <= '0;
        in_ready_q     <= 1'b1;
        cmp_a_q        <= '0;
        cmp_b_q        <= '0;
        new_max_seen_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (InValid && in_ready_q) begin
              sample_q <= InData;
              if (empty) begin
                // First sample seeds both statistics; no compare needed.
                max_q     <= InData;
                min_q     <= InData;
                count_q   <= COUNT_WIDTH'(1);
                update_q  <= 1'b1;
                new_max_q <= 1'b1;
                new_min_q <= 1'b1;
              end else begin
                state_q    <= CMP_MAX;
                in_ready_q <= 1'b0;
                cmp_a_q    <= InData;
                cmp_b_q    <= max_q;
              end
            end
          end
          CMP_MAX: begin
            if (CmpBigA) begin
              max_q <= sample_q;
            end
            new_max_seen_q <= CmpBigA;
            state_q        <= CMP_MIN;
            cmp_a_q        <= sample_q;
            cmp_b_q        <= min_q;
          end
          CMP_MIN: begin
            if (CmpBigB) begin
              min_q <= sample_q;
            end
            count_q    <= count_d;
            update_q   <= 1'b1;
            new_max_q  <= new_max_seen_q;
            new_min_q  <= CmpBigB;
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
            cmp_a_q    <= '0;
            cmp_b_q    <= '0;
          end
          default: begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
            cmp_a_q    <= '0;
            cmp_b_q    <= '0;
          end
        endcase
      end
    end
  end

  assign InReady  = in_ready_q;
  assign CmpA     = cmp_a_q;
  assign CmpB     = cmp_b_q;
  assign Max      = max_q;
  assign Min      = min_q;
  assign Count    = count_q;
  assign Empty    = empty;
  assign Update   = update_q;
  assign NewMax   = new_max_q;
  assign NewMin   = new_min_q;
  assign CmpError = cmp_err_q;

endmodule

// File: tb/tb_minmax_tracker.sv
module tb_minmax_tracker;

  logic       Clk;
  logic       Reset;
  logic       Clear;
  logic       InValid;
  logic [3:0] InData;

  logic       InReady, Empty, Update, NewMax, NewMin, CmpError;
  logic [3:0] CmpA, CmpB, Max, Min;
  logic [7:0] Count;
  logic       CmpEqual, CmpBigA, CmpBigB;

  logic       InReady2, Empty2, Update2, NewMax2, NewMin2, CmpError2;
  logic [3:0] CmpA2, CmpB2, Max2, Min2;
  logic [1:0] Count2;
  logic       CmpEqual2, CmpBigA2, CmpBigB2;

  logic       force_en, force_eq, force_biga, force_bigb;

  int checks;
  int errors;

  // Comparator models (with an override for fault injection on dut)
  assign CmpEqual  = force_en ? force_eq   : (CmpA == CmpB);
  assign CmpBigA   = force_en ? force_biga : (CmpA >  CmpB);
  assign CmpBigB   = force_en ? force_bigb : (CmpA <  CmpB);
  assign CmpEqual2 = (CmpA2 == CmpB2);
  assign CmpBigA2  = (CmpA2 >  CmpB2);
  assign CmpBigB2  = (CmpA2 <  CmpB2);

  minmax_tracker #(.COUNT_WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .Clear(Clear), .InValid(InValid), .InReady(InReady),
    .InData(InData), .CmpA(CmpA), .CmpB(CmpB), .CmpEqual(CmpEqual),
    .CmpBigA(CmpBigA), .CmpBigB(CmpBigB), .Max(Max), .Min(Min), .Count(Count),
    .Empty(Empty), .Update(Update), .NewMax(NewMax), .NewMin(NewMin),
    .CmpError(CmpError)
  );

  minmax_tracker #(.COUNT_WIDTH(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .Clear(Clear), .InValid(InValid), .InReady(InReady2),
    .InData(InData), .CmpA(CmpA2), .CmpB(CmpB2), .CmpEqual(CmpEqual2),
    .CmpBigA(CmpBigA2), .CmpBigB(CmpBigB2), .Max(Max2), .Min(Min2), .Count(Count2),
    .Empty(Empty2), .Update(Update2), .NewMax(NewMax2), .NewMin(NewMin2),
    .CmpError(CmpError2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic do_reset();
    @(negedge Clk); Reset = 1'b1;
    @(negedge Clk); Reset = 1'b0;
  endtask

  // Offers one sample, then waits (bounded) for its Update pulse on dut.
  task automatic feed(input logic [3:0] v, inout int upd2);
    int n;
    n = 0;
    @(negedge Clk); InValid = 1'b1; InData = v;
    while (!InReady && n < 10) begin @(negedge Clk); n++; end
    @(posedge Clk); @(negedge Clk); InValid = 1'b0; InData = 4'd0;
    n = 0;
    while (!Update && n < 5) begin @(negedge Clk); n++; end
    checks++;
    if (Update !== 1'b1) begin errors++; $display("FAIL feed_update_timeout got %b exp 1", Update); end
    if (Update2 === 1'b1) upd2++;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    checks++;
    if ({Max, Min} !== 8'h00) begin errors++; $display("FAIL reset_maxmin got %h exp 00", {Max, Min}); end
    checks++;
    if (Count !== 8'd0 || Empty !== 1'b1) begin errors++; $display("FAIL reset_count got %0d/%b exp 0/1", Count, Empty); end
    checks++;
    if ({Update, NewMax, NewMin, CmpError} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {Update, NewMax, NewMin, CmpError}); end
    checks++;
    if ({CmpA, CmpB} !== 8'h00 || InReady !== 1'b1) begin errors++; $display("FAIL reset_cmp_ready got %h/%b exp 00/1", {CmpA, CmpB}, InReady); end
  endtask

  task automatic test_first_sample();
    @(negedge Clk); InValid = 1'b1; InData = 4'd7;
    @(negedge Clk); InValid = 1'b0;
    checks++;
    if ({Update, NewMax, NewMin} !== 3'b111) begin errors++; $display("FAIL first_flags got %b exp 111", {Update, NewMax, NewMin}); end
    checks++;
    if (Max !== 4'd7 || Min !== 4'd7) begin errors++; $display("FAIL first_maxmin got %0d/%0d exp 7/7", Max, Min); end
    checks++;
    if (Count !== 8'd1 || Empty !== 1'b0) begin errors++; $display("FAIL first_count got %0d/%b exp 1/0", Count, Empty); end
    @(negedge Clk);
    checks++;
    if (Update !== 1'b0) begin errors++; $display("FAIL first_update_pulse got %b exp 0", Update); end
  endtask

  task automatic test_stream();
    logic [3:0] seq [5];
    int acc_cyc [5];
    int upd_cyc [5];
    logic nmx [5];
    logic nmn [5];
    int na, nu;
    seq[0] = 4'd7; seq[1] = 4'd12; seq[2] = 4'd3; seq[3] = 4'd12; seq[4] = 4'd3;
    na = 0; nu = 0;
    do_reset();
    @(negedge Clk); InValid = 1'b1; InData = seq[0];
    for (int cyc = 0; cyc < 40 && nu < 5; cyc++) begin
      if (InValid && InReady) begin acc_cyc[na] = cyc; na++; end
      @(posedge Clk); @(negedge Clk);
      if (na == 5) InValid = 1'b0; else InData = seq[na];
      if (Update) begin upd_cyc[nu] = cyc; nmx[nu] = NewMax; nmn[nu] = NewMin; nu++; end
    end
    InValid = 1'b0;
    checks++;
    if (nu !== 5) begin errors++; $display("FAIL stream_update_count got %0d exp 5", nu); end
    for (int i = 0; i < nu; i++) begin
      checks++;
      if (acc_cyc[i] !== ((i == 0) ? 0 : 3 * i - 2) || upd_cyc[i] !== 3 * i) begin
        errors++;
        $display("FAIL stream_timing[%0d] got acc %0d upd %0d exp acc %0d upd %0d", i, acc_cyc[i], upd_cyc[i], (i == 0) ? 0 : 3 * i - 2, 3 * i);
      end
      checks++;
      if (nmx[i] !== (i <= 1) || nmn[i] !== (i == 0 || i == 2)) begin
        errors++;
        $display("FAIL stream_newflags[%0d] got %b%b exp %b%b", i, nmx[i], nmn[i], (i <= 1), (i == 0 || i == 2));
      end
    end
    checks++;
    if (Max !== 4'd12 || Min !== 4'd3 || Count !== 8'd5) begin errors++; $display("FAIL stream_final got %0d/%0d/%0d exp 12/3/5", Max, Min, Count); end
  endtask

  task automatic test_operands();
    @(negedge Clk); InValid = 1'b1; InData = 4'd5;
    @(negedge Clk); InValid = 1'b0; InData = 4'd0;
    checks++;
    if (InReady !== 1'b0 || CmpA !== 4'd5 || CmpB !== 4'd12) begin errors++; $display("FAIL op_cmp_max got rdy %b A %0d B %0d exp 0/5/12", InReady, CmpA, CmpB); end
    @(negedge Clk);
    checks++;
    if (InReady !== 1'b0 || CmpA !== 4'd5 || CmpB !== 4'd3) begin errors++; $display("FAIL op_cmp_min got rdy %b A %0d B %0d exp 0/5/3", InReady, CmpA, CmpB); end
    @(negedge Clk);
    checks++;
    if (InReady !== 1'b1 || CmpA !== 4'd0 || CmpB !== 4'd0) begin errors++; $display("FAIL op_idle got rdy %b A %0d B %0d exp 1/0/0", InReady, CmpA, CmpB); end
    checks++;
    if ({Update, NewMax, NewMin} !== 3'b100 || Count !== 8'd6) begin errors++; $display("FAIL op_update got %b cnt %0d exp 100 cnt 6", {Update, NewMax, NewMin}, Count); end
  endtask

  task automatic test_clear();
    @(negedge Clk); InValid = 1'b1; InData = 4'd15;
    @(negedge Clk); Clear = 1'b1; InData = 4'd0;
    @(negedge Clk); Clear = 1'b0; InValid = 1'b0;
    checks++;
    if (Max !== 4'd0 || Min !== 4'd0 || Count !== 8'd0 || Empty !== 1'b1) begin errors++; $display("FAIL clear_stats got %0d/%0d/%0d/%b exp 0/0/0/1", Max, Min, Count, Empty); end
    checks++;
    if (Update !== 1'b0 || InReady !== 1'b1 || CmpA !== 4'd0) begin errors++; $display("FAIL clear_idle got upd %b rdy %b A %0d exp 0/1/0", Update, InReady, CmpA); end
    @(negedge Clk);
    checks++;
    if (Update !== 1'b0 || Count !== 8'd0) begin errors++; $display("FAIL clear_no_late_update got %b cnt %0d exp 0/0", Update, Count); end
    Clear = 1'b1; InValid = 1'b1; InData = 4'd9;
    @(negedge Clk); Clear = 1'b0; InValid = 1'b0;
    checks++;
    if (Count !== 8'd0 || Empty !== 1'b1 || Max !== 4'd0 || Update !== 1'b0) begin errors++; $display("FAIL clear_priority got cnt %0d empty %b max %0d upd %b exp 0/1/0/0", Count, Empty, Max, Update); end
  endtask

  task automatic test_cmp_error();
    int dummy;
    dummy = 0;
    feed(4'd4, dummy);
    checks++;
    if (CmpError !== 1'b0) begin errors++; $display("FAIL err_before got %b exp 0", CmpError); end
    @(negedge Clk); InValid = 1'b1; InData = 4'd6;
    @(negedge Clk); InValid = 1'b0;
    force_eq = 1'b1; force_biga = 1'b1; force_bigb = 1'b0; force_en = 1'b1;
    @(negedge Clk); force_en = 1'b0;
    checks++;
    if (CmpError !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", CmpError); end
    @(negedge Clk);
    checks++;
    if (Update !== 1'b1 || NewMax !== 1'b1 || Max !== 4'd6 || Min !== 4'd4) begin errors++; $display("FAIL err_continue got upd %b nmx %b max %0d min %0d exp 1/1/6/4", Update, NewMax, Max, Min); end
    @(negedge Clk); Clear = 1'b1;
    @(negedge Clk); Clear = 1'b0;
    checks++;
    if (CmpError !== 1'b1 || Max !== 4'd0) begin errors++; $display("FAIL err_through_clear got %b max %0d exp 1/0", CmpError, Max); end
    do_reset();
    checks++;
    if (CmpError !== 1'b0) begin errors++; $display("FAIL err_reset got %b exp 0", CmpError); end
  endtask

  task automatic test_saturate();
    int upd2;
    upd2 = 0;
    do_reset();
    feed(4'd0, upd2);
    feed(4'd15, upd2);
    feed(4'd1, upd2);
    feed(4'd14, upd2);
    feed(4'd2, upd2);
    checks++;
    if (Count2 !== 2'd3 || Empty2 !== 1'b0) begin errors++; $display("FAIL sat_count got %0d/%b exp 3/0", Count2, Empty2); end
    checks++;
    if (Max2 !== 4'd15 || Min2 !== 4'd0) begin errors++; $display("FAIL sat_maxmin got %0d/%0d exp 15/0", Max2, Min2); end
    checks++;
    if (upd2 !== 5) begin errors++; $display("FAIL sat_updates got %0d exp 5", upd2); end
    checks++;
    if (Count !== 8'd5) begin errors++; $display("FAIL wide_count got %0d exp 5", Count); end
  endtask

  initial begin
    checks = 0; errors = 0;
    Reset = 1'b1; Clear = 1'b0; InValid = 1'b0; InData = 4'd0;
    force_en = 1'b0; force_eq = 1'b0; force_biga = 1'b0; force_bigb = 1'b0;
    test_reset();
    test_first_sample();
    test_stream();
    test_operands();
    test_clear();
    test_cmp_error();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
